// File: rtl/mem_waitstate_ram.sv
// Single-port RAM behind a req/ready handshake; each access costs WAIT extra cycles, writes are byte-lane masked.
// Define MEM_ROM_GUARD_EN to block writes at or above ROM_BASE (fault pulses with ready instead).
module mem_waitstate_ram #(
    parameter int                ADDR_W    = 20,
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 1 << ADDR_W,
    parameter int                WAIT      = 1,
    parameter string             INIT_FILE = "program.hex",
    parameter logic [ADDR_W-1:0] ROM_BASE  = 'hF0000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req,
    input  logic [ADDR_W-1:0]     cursor,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DATA_W-1:0]     o_data,
    output logic [DATA_W-1:0]     i_data,
    output logic                  ready,
    output logic                  busy,
    output logic                  fault
);
    localparam int         LANES    = DATA_W / 8;
    localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    if (WAIT < 0 || WAIT > 15) begin : g_bad_wait
        $error("mem_waitstate_ram: WAIT must be in 0..15");
    end
    if (DATA_W <= 0 || (DATA_W % 8) != 0) begin : g_bad_data_w
        $error("mem_waitstate_ram: DATA_W must be a positive multiple of 8");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS
    } state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [IDX_W-1:0]    addr_q;
    logic                we_q;
    logic [LANES-1:0]    be_q;
    logic [DATA_W-1:0]   wdat_q;
    logic [DATA_W-1:0]   rdat_q;
    logic                ready_q;
    logic                busy_q;
    logic                fault_q;
    logic                blocked;
    logic                do_write;
    logic                unused_cursor;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Only the low IDX_W cursor bits select a word; upper bits alias.
    assign unused_cursor = ^cursor;

`ifdef MEM_ROM_GUARD_EN
    assign blocked = we_q && (ADDR_W'(addr_q) >= ROM_BASE);
`else
    logic unused_rom_base;
    assign unused_rom_base = ^ROM_BASE;
    assign blocked         = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // busy stays up through the ready cycle and drops here unless a new req arrives.
                    busy_q <= req;
                    if (req) begin
                        addr_q  <= cursor[IDX_W-1:0];
                        we_q    <= we;
                        be_q    <= be;
                        wdat_q  <= o_data;
                        cnt_q   <= CNT_INIT;
                        state_q <= (WAIT > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_ACCESS;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_ACCESS: begin
                    ready_q <= 1'b1;
                    fault_q <= blocked;
                    if (!we_q) rdat_q <= mem[addr_q];
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Gate on reset so an access aborted by reset near the ACCESS edge never commits.
    assign do_write = (state_q == S_ACCESS) && we_q && !blocked && !reset;

    always_ff @(posedge clock) begin
        if (do_write) begin
            for (int k = 0; k < LANES; k++) begin
                if (be_q[k]) mem[addr_q][k*8 +: 8] <= wdat_q[k*8 +: 8];
            end
        end
    end

    assign i_data = rdat_q;
    assign ready  = ready_q;
    assign busy   = busy_q;
    assign fault  = fault_q;
endmodule
